xdiv_seq: RTL and testbench

XDIV_SEQ -- requirements
Module: xdiv_seq

---
 rtl/xdiv_seq_pkg.sv | 14 +
 rtl/xdiv_seq_step.sv | 28 ++
 rtl/xdiv_seq.sv | 142 ++++++++++++++
 tb/tb_xdiv_seq.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/xdiv_seq_pkg.sv
// Shared definitions for the sequential divider: default width and FSM state encodings.
package xdiv_seq_pkg;

  localparam int XDIV_DATA_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_CALC = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } xdiv_state_e;

endpackage

// File: rtl/xdiv_seq_step.sv
// One radix-2 restoring division step: shift in the next dividend bit, trial-subtract, select.
module xdiv_step
  import xdiv_seq_pkg::*;
#(
  parameter int DATA_W = XDIV_DATA_W
) (
  input  logic [DATA_W-1:0] rem_i,
  input  logic [DATA_W-1:0] quo_i,
  input  logic [DATA_W-1:0] dsr_i,
  output logic [DATA_W-1:0] rem_o,
  output logic [DATA_W-1:0] quo_o
);

  logic [DATA_W:0] shifted;
  logic [DATA_W:0] diff;
  logic            q_bit;

  // With rem_i < dsr_i the shifted value stays below 2*dsr_i, so the top bit of
  // the DATA_W+1-bit difference is a clean borrow flag.
  always_comb begin
    shifted = {rem_i, quo_i[DATA_W-1]};
    diff    = shifted - {1'b0, dsr_i};
    q_bit   = ~diff[DATA_W];
    rem_o   = q_bit ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
    quo_o   = {quo_i[DATA_W-2:0], q_bit};
  end

endmodule

// File: rtl/xdiv_seq.sv
// Fixed-latency sequential divider (signed/unsigned), one restoring step per cycle.
module xdiv_seq
  import xdiv_seq_pkg::*;
#(
  parameter int DATA_W = XDIV_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              sign_en,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);

  localparam int CNT_W = $clog2(DATA_W);

  xdiv_state_e       state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic              sgn_q, sgn_d;
  logic [DATA_W-1:0] quo_q, quo_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] dsr_q, dsr_d;
  logic              negq_q, negq_d;
  logic              negr_q, negr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] quotient_q, quotient_d;
  logic [DATA_W-1:0] remainder_q, remainder_d;
  logic [DATA_W-1:0] rem_step, quo_step;

  function automatic logic signed [DATA_W-1:0] negate(input logic signed [DATA_W-1:0] x);
    return -x;
  endfunction

  function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] x, input logic s);
    return (s && x[DATA_W-1]) ? negate(x) : x;
  endfunction

  xdiv_step #(.DATA_W(DATA_W)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dsr_i (dsr_q),
    .rem_o (rem_step),
    .quo_o (quo_step)
  );

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sgn_d       = sgn_q;
    quo_d       = quo_q;
    rem_d       = rem_q;
    dsr_d       = dsr_q;
    negq_d      = negq_q;
    negr_d      = negr_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = op_a;
          b_d     = op_b;
          sgn_d   = sign_en;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        quo_d   = magnitude(a_q, sgn_q);
        dsr_d   = magnitude(b_q, sgn_q);
        rem_d   = '0;
        negq_d  = sgn_q & (a_q[DATA_W-1] ^ b_q[DATA_W-1]);
        negr_d  = sgn_q & a_q[DATA_W-1];
        cnt_d   = CNT_W'(DATA_W - 1);
        state_d = ST_CALC;
      end
      ST_CALC: begin
        rem_d = rem_step;
        quo_d = quo_step;
        if (cnt_q == '0) begin
          state_d = ST_FIX;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_FIX: begin
        // Divide by zero bypasses the iterated result: all-ones quotient, raw dividend.
        if (b_q == '0) begin
          quotient_d  = '1;
          remainder_d = a_q;
        end else begin
          quotient_d  = negq_q ? negate(quo_q) : quo_q;
          remainder_d = negr_q ? negate(rem_q) : rem_q;
        end
        state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sgn_q       <= 1'b0;
      quo_q       <= '0;
      rem_q       <= '0;
      dsr_q       <= '0;
      negq_q      <= 1'b0;
      negr_q      <= 1'b0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sgn_q       <= sgn_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      dsr_q       <= dsr_d;
      negq_q      <= negq_d;
      negr_q      <= negr_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign quotient  = quotient_q;
  assign remainder = remainder_q;

endmodule

// File: tb/tb_xdiv_seq.sv
// Scoreboard bench for xdiv_seq: stimulus queues expected results, a monitor checks each done pulse.
module tb_xdiv_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic        sign_en;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    int          e;
  } exp_t;

  exp_t        sb_q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          edge_cnt = 0;
  bit          hold_en = 0;
  bit          busy_chk = 0;
  logic [31:0] last_q = '0;
  logic [31:0] last_r = '0;

  xdiv_seq #(.DATA_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sign_en   (sign_en),
    .op_a      (op_a),
    .op_b      (op_b),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt++;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (edge %0d)", nm, act, exp, edge_cnt);
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge
  always @(posedge clk) begin
    exp_t x;
    #1;
    if (rst) begin
      last_q = '0;
      last_r = '0;
    end
    if (busy_chk) begin
      check("busy_after_done", {31'b0, busy}, 32'd0);
      busy_chk = 0;
    end
    if (done) begin
      if (sb_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1, expected no pulse (edge %0d)", edge_cnt);
      end else begin
        x = sb_q.pop_front();
        check("quotient", quotient, x.q);
        check("remainder", remainder, x.r);
        check("done_edge", edge_cnt, x.e);
      end
      last_q   = quotient;
      last_r   = remainder;
      busy_chk = 1;
    end else if (hold_en) begin
      check("hold_quotient", quotient, last_q);
      check("hold_remainder", remainder, last_r);
    end
  end

  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                output logic [31:0] q, output logic [31:0] r);
    int sa, sb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!s) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = a;
      r = 32'd0;
    end else begin
      sa = a;
      sb = b;
      q = sa / sb;
      r = sa % sb;
    end
  endfunction

  task automatic drain(input int acc);
    for (int i = 0; i < 60 && sb_q.size() != 0; i++) begin
      @(negedge clk);
      op_a    = $urandom;
      op_b    = $urandom;
      sign_en = 1'($urandom);
      start   = (edge_cnt == acc + 5) || (edge_cnt == acc + 34);
    end
    if (sb_q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL timeout: got %0d pending results, expected 0", sb_q.size());
      sb_q.delete();
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [31:0] eq, input logic [31:0] er);
    int acc;
    @(negedge clk);
    op_a    = a;
    op_b    = b;
    sign_en = s;
    start   = 1'b1;
    acc     = edge_cnt + 1;
    sb_q.push_back('{q: eq, r: er, e: acc + 34});
    @(negedge clk);
    start = 1'b0;
    drain(acc);
  endtask

  initial begin
    int          acc;
    logic [31:0] a, b, eq, er;
    logic        s;

    rst = 1'b1; start = 1'b0; sign_en = 1'b0; op_a = '0; op_b = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_quotient", quotient, 32'd0);
    check("rst_remainder", remainder, 32'd0);
    rst = 1'b0;
    hold_en = 1;

    // Directed vectors
    run_op(32'd100,       32'd7,         1'b0, 32'd14,        32'd2);
    run_op(32'hFFFF_FFF9, 32'd2,         1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    run_op(32'hFFFF_FFF9, 32'd2,         1'b0, 32'h7FFF_FFFC, 32'd1);
    run_op(32'd5,         32'd0,         1'b0, 32'hFFFF_FFFF, 32'd5);
    run_op(32'd5,         32'd0,         1'b1, 32'hFFFF_FFFF, 32'd5);
    run_op(32'hFFFF_FFFB, 32'd0,         1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFB);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0,         32'h8000_0000);
    run_op(32'd7,         32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1);
    run_op(32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, 32'd3,         32'hFFFF_FFFF);
    run_op(32'hFFFF_FFFF, 32'd1,         1'b0, 32'hFFFF_FFFF, 32'd0);

    // start held high with operands changing every cycle
    @(negedge clk);
    acc = edge_cnt + 1;
    for (int i = 0; i <= 36; i++) begin
      start = 1'b1;
      if (i == 0) begin
        op_a = 32'd1000; op_b = 32'd7; sign_en = 1'b0;
        sb_q.push_back('{q: 32'd142, r: 32'd6, e: acc + 34});
      end else if (i == 36) begin
        op_a = 32'hFFFF_FF9C; op_b = 32'd9; sign_en = 1'b1;
        sb_q.push_back('{q: 32'hFFFF_FFF5, r: 32'hFFFF_FFFF, e: acc + 70});
      end else begin
        op_a = $urandom; op_b = $urandom; sign_en = 1'($urandom);
      end
      @(negedge clk);
    end
    start = 1'b0;
    drain(acc + 36);

    // Reset during CALC: no done, outputs cleared
    @(negedge clk);
    op_a = 32'd12345678; op_b = 32'd3; sign_en = 1'b0; start = 1'b1;
    acc = edge_cnt + 1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    check("abort_quotient", quotient, 32'd0);
    check("abort_remainder", remainder, 32'd0);
    repeat (40) @(negedge clk);
    run_op(32'd1000, 32'd10, 1'b0, 32'd100, 32'd0);

    // Random operands against the reference model
    for (int i = 0; i < 300; i++) begin
      a = $urandom;
      b = $urandom;
      s = 1'(i);
      if (i % 8 == 0) b = $urandom_range(0, 3);
      if (i % 8 == 1) b = 32'hFFFF_FFFF;
      if (i % 16 == 1) a = 32'h8000_0000;
      if (i % 8 == 2) b = $urandom_range(1, 1000);
      model(a, b, s, eq, er);
      run_op(a, b, s, eq, er);
    end

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
